// File: rtl/uart_matrix_loader.sv
// uart_matrix_loader: turns the UART byte stream into two N x N operand matrices
// (A then B, row-major), fires the multiplier once both are loaded, and waits
// for mult_done. A long gap between bytes inside a frame aborts the frame.
module uart_matrix_loader #(
    parameter int unsigned N              = 10,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_ready,
    input  logic                 mult_done,
    output logic                 wr_en,
    output logic                 wr_sel,
    output logic [$clog2(N)-1:0] wr_row,
    output logic [$clog2(N)-1:0] wr_col,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 start,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_FIRE,
        S_WAIT_MULT
    } state_t;

    state_t           state;
    logic             rx_ready_d;
    logic             sel;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic [TMO_W-1:0] tmo;

    logic             strobe_c;
    logic             last_elem_c;
    logic             sel_nx_c;
    logic [IDX_W-1:0] row_nx_c;
    logic [IDX_W-1:0] col_nx_c;
    state_t           load_nx_c;

    // Rising edge of the UART ready level: one strobe per byte.
    assign strobe_c    = rx_ready & ~rx_ready_d;
    assign last_elem_c = (row == LAST_IDX) && (col == LAST_IDX);

    // Next write position (row-major, wraps into the other matrix) and the
    // load state that follows the current write.
    always_comb begin
        sel_nx_c  = sel;
        row_nx_c  = row;
        col_nx_c  = col + IDX_W'(1);
        load_nx_c = sel ? S_LOAD_B : S_LOAD_A;
        if (col == LAST_IDX) begin
            col_nx_c = '0;
            if (row == LAST_IDX) begin
                row_nx_c = '0;
                sel_nx_c = ~sel;
            end else begin
                row_nx_c = row + IDX_W'(1);
            end
        end
        if (last_elem_c) begin
            load_nx_c = sel ? S_FIRE : S_LOAD_B;
        end
    end

    // Loader FSM with registered write port, handshake and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            rx_ready_d <= 1'b0;
            sel        <= 1'b0;
            row        <= '0;
            col        <= '0;
            tmo        <= '0;
            wr_en      <= 1'b0;
            wr_sel     <= 1'b0;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_data    <= '0;
            start      <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_ready_d <= rx_ready;
            wr_en      <= 1'b0;
            start      <= 1'b0;
            case (state)
                S_IDLE, S_LOAD_A, S_LOAD_B: begin
                    if (strobe_c) begin
                        // A strobe always wins over an expiring timeout.
                        wr_en   <= 1'b1;
                        wr_sel  <= sel;
                        wr_row  <= row;
                        wr_col  <= col;
                        wr_data <= DATA_W'(rx_data);
                        sel     <= sel_nx_c;
                        row     <= row_nx_c;
                        col     <= col_nx_c;
                        tmo     <= '0;
                        state   <= load_nx_c;
                        if (state == S_IDLE) begin
                            frame_err <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end else if (state != S_IDLE) begin
                        if (tmo == TMO_LAST) begin
                            // Abort: buffer contents stay, indices restart.
                            state     <= S_IDLE;
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                            overrun   <= 1'b0;
                            sel       <= 1'b0;
                            row       <= '0;
                            col       <= '0;
                            tmo       <= '0;
                        end else begin
                            tmo <= tmo + TMO_W'(1);
                        end
                    end
                end
                S_FIRE: begin
                    start <= 1'b1;
                    tmo   <= '0;
                    state <= S_WAIT_MULT;
                end
                S_WAIT_MULT: begin
                    tmo <= '0;
                    if (mult_done) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        overrun <= 1'b0;
                    end else if (strobe_c) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_matrix_loader.sv
// tb_uart_matrix_loader: directed sequence with random payloads, checked against
// an index-arithmetic model of the expected write stream and a shadow buffer.
module tb_uart_matrix_loader;

    localparam int unsigned N   = 10;
    localparam int unsigned DW  = 8;
    localparam int unsigned TMO = 12000;
    localparam int unsigned NN  = N * N;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       mult_done = 1'b0;
    logic       wr_en;
    logic       wr_sel;
    logic [3:0] wr_row;
    logic [3:0] wr_col;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_matrix_loader #(
        .N(N),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .mult_done(mult_done),
        .wr_en(wr_en),
        .wr_sel(wr_sel),
        .wr_row(wr_row),
        .wr_col(wr_col),
        .wr_data(wr_data),
        .start(start),
        .busy(busy),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic [3:0] row;
        logic [3:0] col;
        logic [7:0] data;
        longint     cyc;
    } wr_t;

    wr_t        wq[$];
    int         start_cnt = 0;
    longint     start_cyc = 0;
    longint     cyc = 0;
    logic [7:0] mem_a[N][N];
    logic [7:0] mem_b[N][N];
    int         checks = 0;
    int         failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the operand write port and start pulses; emulate the buffers.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wq.push_back('{sel: wr_sel, row: wr_row, col: wr_col, data: wr_data, cyc: cyc});
            if (wr_row < 4'(N) && wr_col < 4'(N)) begin
                if (wr_sel === 1'b0) mem_a[wr_row][wr_col] = wr_data;
                else                 mem_b[wr_row][wr_col] = wr_data;
            end
        end
        if (start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (hi) @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        mult_done = 1'b1;
        @(negedge clk);
        mult_done = 1'b0;
    endtask

    // Element k of a frame lands in matrix k/NN at row (k%NN)/N, column k%N.
    task automatic check_frame(input string tag, input int first, input logic [7:0] bytes[$]);
        int bad = 0;
        for (int k = 0; k < bytes.size(); k++) begin
            if (first + k >= wq.size()) begin
                bad++;
            end else if (wq[first+k].sel !== 1'(k / NN) ||
                         wq[first+k].row !== 4'((k % NN) / N) ||
                         wq[first+k].col !== 4'(k % N) ||
                         wq[first+k].data !== bytes[k]) begin
                bad++;
            end
        end
        check(tag, bad, 0);
    endtask

    task automatic check_mem(input string tag, input logic [7:0] bytes[$]);
        int bad = 0;
        for (int k = 0; k < int'(2 * NN); k++) begin
            if (k / NN == 0) begin
                if (mem_a[(k % NN) / N][k % N] !== bytes[k]) bad++;
            end else begin
                if (mem_b[(k % NN) / N][k % N] !== bytes[k]) bad++;
            end
        end
        check(tag, bad, 0);
    endtask

    logic [7:0] q[$];
    logic [7:0] b;
    int         base;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_wr_pos", {wr_sel, wr_row, wr_col}, 0);
        check("rst_wr_data", wr_data, 0);
        reset = 1'b1;

        // 1: full frame 0x00..0xC7
        q = {};
        for (int i = 0; i < 200; i++) begin
            q.push_back(8'(i));
            send_byte(8'(i), 5);
            if (i == 0) check("t1_busy_first", busy, 1);
        end
        repeat (5) @(negedge clk);
        check("t1_wr_count", wq.size(), 200);
        check_frame("t1_wr_seq", 0, q);
        check_mem("t1_buffers", q);
        check("t1_start_count", start_cnt, 1);
        check("t1_start_latency", start_cyc - wq[wq.size()-1].cyc, 1);
        check("t1_busy_wait", busy, 1);

        // 5: bytes during WAIT_MULT are dropped and flag overrun
        base = wq.size();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 4);
        check("t5_no_write", wq.size(), base);
        check("t5_overrun", overrun, 1);
        check("t5_busy", busy, 1);
        pulse_done();
        check("t5_busy_done", busy, 0);
        check("t5_overrun_clr", overrun, 0);
        check("t5_start_once", start_cnt, 1);

        // 2: one long rx_ready high time gives exactly one write
        base = wq.size();
        q = {};
        b = 8'($urandom);
        q.push_back(b);
        send_byte(b, 10000);
        check("t2_one_write", wq.size(), base + 1);

        // 3: 37 bytes then silence aborts the frame
        for (int i = 1; i < 37; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            send_byte(b, 3);
        end
        check_frame("t3_partial_seq", base, q);
        repeat (TMO - 20) @(negedge clk);
        check("t3_busy_pre_tmo", busy, 1);
        check("t3_ferr_pre_tmo", frame_err, 0);
        repeat (40) @(negedge clk);
        check("t3_frame_err", frame_err, 1);
        check("t3_busy", busy, 0);
        check("t3_no_start", start_cnt, 1);
        check("t3_wr_count", wq.size(), base + 37);
        base = wq.size();
        q = {};
        b = 8'($urandom);
        q.push_back(b);
        send_byte(b, 3);
        check_frame("t3_restart_a00", base, q);
        check("t3_ferr_clr", frame_err, 0);
        check("t3_busy_again", busy, 1);

        // 4: strobe exactly TMO cycles after the previous one still counts
        b = 8'($urandom);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        q.push_back(b);
        repeat (5) @(negedge clk);
        rx_ready = 1'b0;
        repeat (TMO - 5) @(negedge clk);
        b = 8'($urandom);
        rx_data  = b;
        rx_ready = 1'b1;
        q.push_back(b);
        repeat (3) @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_no_abort", frame_err, 0);
        check("t4_busy", busy, 1);
        check_frame("t4_seq", base, q);

        // 6: reset in the middle of matrix B
        while (q.size() < 150) begin
            b = 8'($urandom);
            q.push_back(b);
            send_byte(b, $urandom_range(1, 6));
        end
        check_frame("t6_pre_reset_seq", base, q);
        check("t6_busy_pre", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_outputs_zero", {wr_en, start, busy, frame_err, overrun, wr_sel, wr_row, wr_col, wr_data}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        base = wq.size();
        q = {};
        for (int i = 0; i < 200; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            send_byte(b, $urandom_range(1, 6));
        end
        repeat (5) @(negedge clk);
        check("t6_wr_count", wq.size(), base + 200);
        check_frame("t6_fresh_seq", base, q);
        check_mem("t6_buffers", q);
        check("t6_start_count", start_cnt, 2);
        check("t6_start_latency", start_cyc - wq[wq.size()-1].cyc, 1);
        pulse_done();
        check("t6_busy_done", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
